// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the serialiser state encoding.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  localparam int ST_FULL     = 0;
  localparam int ST_EMPTY    = 1;
  localparam int ST_BUSY     = 2;
  localparam int ST_IRQ_PEND = 3;
  localparam int ST_OVF      = 4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_PAR_EN = 2;
  localparam int CTRL_ODD    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO with extra-MSB pointers; a push into a full FIFO
// is accepted only when a pop frees a slot on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the data bus with TX FIFO and level irq.
// Define UART_PARITY_EN to add CTRL parity enable/odd bits and a PARITY frame slot.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        txd,
  output logic        irq
);

  tx_state_t   state;
  tx_state_t   next_state;
  logic [1:0]  reg_sel;
  logic        wr;
  logic        push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        en;
  logic        ie;
  logic        par_en;
  logic        par_odd;
  logic        ovf;
  logic [15:0] bauddiv;
  logic [15:0] baud_cnt;
  logic        baud_zero;
  logic        bit_edge;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        par_bit;
  logic        busy;
  logic        irq_pend;
  logic        unused_bits;

  assign reg_sel     = addr[3:2];
  assign wr          = ce && we;
  assign push        = wr && (reg_sel == REG_TXDATA);
  assign baud_zero   = (baud_cnt == 16'd0);
  assign bit_edge    = (state != S_IDLE) && baud_zero;
  assign busy        = (state != S_IDLE);
  assign irq_pend    = fifo_empty && !busy;
  assign unused_bits = ^{addr[31:4], addr[1:0], wtData[31:16]};

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (fifo_pop),
    .din  (wtData[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      bauddiv <= DEFAULT_DIV;
      ovf     <= 1'b0;
    end else begin
      if (wr && reg_sel == REG_CTRL) begin
        en <= wtData[CTRL_EN];
        ie <= wtData[CTRL_IE];
      end
      if (wr && reg_sel == REG_BAUDDIV) bauddiv <= wtData[15:0];
      // A push is only lost when the FIFO is full and nothing drains this edge.
      if (push && fifo_full && !fifo_pop)
        ovf <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && wtData[ST_OVF])
        ovf <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en  <= 1'b0;
      par_odd <= 1'b0;
    end else if (wr && reg_sel == REG_CTRL) begin
      par_en  <= wtData[CTRL_PAR_EN];
      par_odd <= wtData[CTRL_ODD];
    end
  end
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (en && !fifo_empty) begin
          next_state = S_START;
          fifo_pop   = 1'b1;
        end
      end
      S_START:  if (baud_zero) next_state = S_DATA;
      S_DATA:   if (baud_zero && bit_cnt == 3'd7) next_state = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (baud_zero) next_state = S_STOP;
      S_STOP: begin
        if (baud_zero) begin
          if (en && !fifo_empty) begin
            next_state = S_START;
            fifo_pop   = 1'b1;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    unique case (state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shift_reg[0];
      S_PARITY: txd = par_bit;
      default:  txd = 1'b1;
    endcase
  end

  // Bit timer reloads from BAUDDIV at every boundary, so a new divisor only
  // affects the bit that starts after the write.
  always_ff @(posedge clk) begin
    if (rst)                       baud_cnt <= 16'd0;
    else if (fifo_pop || bit_edge) baud_cnt <= bauddiv;
    else if (!baud_zero)           baud_cnt <= baud_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= 8'hFF;
      bit_cnt   <= 3'd0;
      par_bit   <= 1'b0;
    end else if (fifo_pop) begin
      shift_reg <= fifo_dout;
      bit_cnt   <= 3'd0;
      par_bit   <= (^fifo_dout) ^ par_odd;
    end else if (state == S_DATA && baud_zero) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= ie && irq_pend;
  end

  always_comb begin
    rdData = 32'd0;
    if (ce && !we) begin
      unique case (reg_sel)
        REG_STATUS:  rdData = {27'd0, ovf, irq_pend, busy, fifo_empty, fifo_full};
        REG_CTRL:    rdData = {28'd0, par_odd, par_en, ie, en};
        REG_BAUDDIV: rdData = {16'd0, bauddiv};
        default:     rdData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed bus writes push expected frames
// into a scoreboard, and a serial monitor on txd pops and checks them bit by bit.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TXDATA  = 32'h0000_7F00;
  localparam logic [31:0] A_STATUS  = 32'h0000_7F04;
  localparam logic [31:0] A_CTRL    = 32'h0000_7F08;
  localparam logic [31:0] A_BAUDDIV = 32'h0000_7F0C;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wtData;
  logic [31:0] rdData;
  logic        txd;
  logic        irq;

  typedef struct {
    logic [7:0] data;
    bit         has_par;
    bit         par;
    bit         b2b;
  } frame_t;

  frame_t sb[$];
  int     checks = 0;
  int     failures = 0;
  int     tb_period = 434;
  int     cyc = 0;
  bit     mon_en = 1'b0;
  bit     mon_busy = 1'b0;

  uart_tx_mmio #(
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .we    (we),
    .addr  (addr),
    .wtData(wtData),
    .rdData(rdData),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Bus write: takes effect at the posedge inside this task.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; wtData = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdData;
    ce = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    read_reg(a, d);
    checkOutput(name, d, exp);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_timeout"}, 32'(n >= 3000), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_txd"}, 32'(txd), 32'd1);
    checkOutput({tag, "_irq"}, 32'(irq), 32'd0);
    expect_reg({tag, "_status"}, A_STATUS, 32'h0000_000A);
    expect_reg({tag, "_ctrl"}, A_CTRL, 32'h0);
    expect_reg({tag, "_bauddiv"}, A_BAUDDIV, 32'd433);
  endtask

  // Serial monitor: on a falling edge of txd, pop the expected frame and check
  // that every bit holds the expected level for exactly one bit period.
  initial begin : monitor
    logic   prev;
    frame_t f;
    int     p;
    int     start_cyc;
    int     last_end;
    int     nbits;
    int     match_cnt;
    int     fidx;
    logic   exp_bit;
    bit     have;
    prev = 1'b1;
    last_end = -100;
    fidx = 0;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && txd === 1'b0) begin
        mon_busy = 1'b1;
        start_cyc = cyc;
        p = tb_period;
        have = (sb.size() != 0);
        checkOutput("frame_expected", 32'(have), 32'd1);
        if (have) begin
          f = sb.pop_front();
          if (f.b2b)
            checkOutput($sformatf("frame%0d_b2b_start_cycle", fidx), start_cyc, last_end + 1);
          nbits = f.has_par ? 11 : 10;
          for (int b = 0; b < nbits; b++) begin
            if (b == 0)                      exp_bit = 1'b0;
            else if (b <= 8)                 exp_bit = f.data[b-1];
            else if (f.has_par && b == 9)    exp_bit = f.par;
            else                             exp_bit = 1'b1;
            match_cnt = 0;
            for (int c = 0; c < p; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (txd === exp_bit) match_cnt++;
            end
            checkOutput($sformatf("frame%0d_bit%0d_cycles_at_level", fidx, b), match_cnt, p);
          end
          last_end = cyc;
          fidx++;
        end
        mon_busy = 1'b0;
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int hi_cnt;
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'd0; wtData = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_reset_state("reset");
    expect_reg("txdata_reads_zero", A_TXDATA, 32'h0);
    @(negedge clk);
    addr = A_STATUS; ce = 1'b0; we = 1'b0;
    #1;
    checkOutput("rddata_zero_without_ce", rdData, 32'h0);
    mon_en = 1'b1;

    // 0x55 at BAUDDIV=3: alternating bits, 4 cycles each, fall one edge after the write
    applyStimulus(A_BAUDDIV, 32'hFFFF_0003);
    tb_period = 4;
    expect_reg("bauddiv_masked", A_BAUDDIV, 32'h0000_0003);
    applyStimulus(A_CTRL, 32'h1);
    sb.push_back('{data: 8'h55, has_par: 1'b0, par: 1'b0, b2b: 1'b0});
    applyStimulus(A_TXDATA, 32'h0000_0055);
    @(negedge clk);
    checkOutput("txd_high_after_write_edge", 32'(txd), 32'd1);
    @(negedge clk);
    checkOutput("txd_falls_next_edge", 32'(txd), 32'd0);
    expect_reg("status_busy_empty", A_STATUS, 32'h0000_0006);
    wait_idle("frame_55");

    // BAUDDIV=0: one clock per bit
    applyStimulus(A_BAUDDIV, 32'h0);
    tb_period = 1;
    sb.push_back('{data: 8'hC3, has_par: 1'b0, par: 1'b0, b2b: 1'b0});
    applyStimulus(A_TXDATA, 32'h0000_00C3);
    wait_idle("frame_div0");

    // Two queued bytes leave back to back
    applyStimulus(A_BAUDDIV, 32'h2);
    tb_period = 3;
    sb.push_back('{data: 8'hA5, has_par: 1'b0, par: 1'b0, b2b: 1'b0});
    sb.push_back('{data: 8'h3C, has_par: 1'b0, par: 1'b0, b2b: 1'b1});
    applyStimulus(A_TXDATA, 32'h0000_00A5);
    applyStimulus(A_TXDATA, 32'h0000_003C);
    wait_idle("frames_b2b");

    // Fill with the serialiser stopped: full after 8, overflow after 9
    applyStimulus(A_CTRL, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(A_TXDATA, 32'h10 + k);
      expect_reg($sformatf("status_after_push%0d", k), A_STATUS,
                 ((k >= 8) ? 32'h1 : 32'h0) | ((k >= 9) ? 32'h10 : 32'h0));
    end
    applyStimulus(A_STATUS, 32'h10);
    expect_reg("status_ovf_cleared", A_STATUS, 32'h0000_0001);

    // Reset in the middle of the data bits
    mon_en = 1'b0;
    applyStimulus(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    expect_reg("status_mid_frame", A_STATUS, 32'h0000_0004);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset_mid_frame");
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    // Interrupt: low for the whole frame, high one edge after STOP ends
    applyStimulus(A_BAUDDIV, 32'h3);
    tb_period = 4;
    sb.push_back('{data: 8'h96, has_par: 1'b0, par: 1'b0, b2b: 1'b0});
    applyStimulus(A_TXDATA, 32'h0000_0096);
    applyStimulus(A_CTRL, 32'h3);
    hi_cnt = 0;
    for (int i = 0; i <= 41; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) hi_cnt++;
    end
    checkOutput("irq_low_while_busy", hi_cnt, 32'd0);
    @(negedge clk);
    checkOutput("irq_rises_after_stop", 32'(irq), 32'd1);
    expect_reg("status_irq_pend", A_STATUS, 32'h0000_000A);
    applyStimulus(A_CTRL, 32'h1);
    @(negedge clk);
    checkOutput("irq_registered_lag", 32'(irq), 32'd1);
    @(negedge clk);
    checkOutput("irq_cleared_by_ie0", 32'(irq), 32'd0);
    wait_idle("frame_irq");

`ifdef UART_PARITY_EN
    applyStimulus(A_CTRL, 32'h5);
    expect_reg("ctrl_parity_even", A_CTRL, 32'h5);
    sb.push_back('{data: 8'h07, has_par: 1'b1, par: 1'b1, b2b: 1'b0});
    applyStimulus(A_TXDATA, 32'h0000_0007);
    wait_idle("frame_par_even");
    applyStimulus(A_CTRL, 32'hD);
    expect_reg("ctrl_parity_odd", A_CTRL, 32'hD);
    sb.push_back('{data: 8'h07, has_par: 1'b1, par: 1'b0, b2b: 1'b0});
    applyStimulus(A_TXDATA, 32'h0000_0007);
    wait_idle("frame_par_odd");
`else
    applyStimulus(A_CTRL, 32'hF);
    expect_reg("ctrl_no_parity_bits", A_CTRL, 32'h3);
    sb.push_back('{data: 8'h07, has_par: 1'b0, par: 1'b0, b2b: 1'b0});
    applyStimulus(A_TXDATA, 32'h0000_0007);
    wait_idle("frame_no_parity");
`endif

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
